// File: rtl/ifu_pkg.sv
// Shared IFU constants and types for the instruction-cache line-fill path.
// Optional FETCH abort support is enabled by defining IFU_RSP_ABORT_EN.
package ifu_pkg;

    localparam int unsigned ADDR_WIDTH   = 32;
    localparam int unsigned OFFSET_WIDTH = 4;
    localparam int unsigned TAG_WIDTH    = ADDR_WIDTH - OFFSET_WIDTH;
    localparam int unsigned LINE_WIDTH   = 128;
    localparam int unsigned WORD_WIDTH   = 32;
    localparam int unsigned RSP_BEATS    = LINE_WIDTH / WORD_WIDTH;
    localparam int unsigned BEAT_WIDTH   = $clog2(RSP_BEATS);

    typedef enum logic [1:0] {
        RSP_IDLE,
        RSP_FETCH,
        RSP_RESP
    } rsp_state_t;

endpackage

// File: rtl/ifu_mem_responder.sv
// Line-fill responder: fetches a cache line as in-order word reads, with a one-entry last-line buffer.
// Define IFU_RSP_ABORT_EN to abandon a fetch (after draining) when the request drops or changes tag.
module ifu_mem_responder #(
    parameter int unsigned ADDR_WIDTH   = ifu_pkg::ADDR_WIDTH,
    parameter int unsigned OFFSET_WIDTH = ifu_pkg::OFFSET_WIDTH,
    parameter int unsigned TAG_WIDTH    = ADDR_WIDTH - OFFSET_WIDTH,
    parameter int unsigned LINE_WIDTH   = ifu_pkg::LINE_WIDTH,
    parameter int unsigned WORD_WIDTH   = ifu_pkg::WORD_WIDTH
) (
    input  logic                  Clock,
    input  logic                  Rst_n,
    input  logic [TAG_WIDTH-1:0]  req_tagIn,
    input  logic                  req_tagValidIn,
    output logic [TAG_WIDTH-1:0]  rsp_tagOut,
    output logic [LINE_WIDTH-1:0] rsp_lineOut,
    output logic                  rsp_lineValidOut,
    output logic                  mem_rdReqOut,
    output logic [ADDR_WIDTH-1:0] mem_rdAddrOut,
    input  logic                  mem_rdReadyIn,
    input  logic [WORD_WIDTH-1:0] mem_rdDataIn,
    input  logic                  mem_rdDataValidIn,
    output logic                  busyOut
);

    localparam int unsigned RSP_BEATS  = LINE_WIDTH / WORD_WIDTH;
    localparam int unsigned BEAT_WIDTH = $clog2(RSP_BEATS);
    localparam int unsigned CNT_WIDTH  = BEAT_WIDTH + 1;
    localparam int unsigned BYTE_BITS  = $clog2(WORD_WIDTH / 8);
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(RSP_BEATS - 1);
    localparam logic [CNT_WIDTH-1:0] ALL_BEATS = CNT_WIDTH'(RSP_BEATS);

    import ifu_pkg::*;

    rsp_state_t state, stateNext;

    logic [TAG_WIDTH-1:0]  curTag;
    logic [TAG_WIDTH-1:0]  bufTag;
    logic [LINE_WIDTH-1:0] lineReg;
    logic [LINE_WIDTH-1:0] bufLine;
    logic [LINE_WIDTH-1:0] lineNext;
    logic                  bufValid;
    logic [CNT_WIDTH-1:0]  issueCnt;
    logic [CNT_WIDTH-1:0]  rcvCnt;
    logic                  bufHit;
    logic                  rdAccept;
    logic                  rcvBeat;
    logic                  lastBeat;
`ifdef IFU_RSP_ABORT_EN
    logic                  abortReg;
    logic                  aborting;
    logic [CNT_WIDTH-1:0]  rcvNext;
`endif

    always_comb begin
        bufHit   = bufValid && (bufTag == req_tagIn);
        rcvBeat  = (state == RSP_FETCH) && mem_rdDataValidIn && (rcvCnt < ALL_BEATS);
        lastBeat = rcvBeat && (rcvCnt == LAST_BEAT);

        lineNext = lineReg;
        for (int unsigned b = 0; b < RSP_BEATS; b++) begin
            if (rcvCnt == CNT_WIDTH'(b)) begin
                lineNext[b*WORD_WIDTH +: WORD_WIDTH] = mem_rdDataIn;
            end
        end

`ifdef IFU_RSP_ABORT_EN
        // Abort is sticky so a request that reappears mid-drain cannot restart issuing.
        aborting = (state == RSP_FETCH) &&
                   (abortReg || !req_tagValidIn || (req_tagIn != curTag));
        rcvNext  = rcvCnt + CNT_WIDTH'(rcvBeat);
        mem_rdReqOut = (state == RSP_FETCH) && (issueCnt < ALL_BEATS) && !aborting;
`else
        mem_rdReqOut = (state == RSP_FETCH) && (issueCnt < ALL_BEATS);
`endif
        rdAccept = mem_rdReqOut && mem_rdReadyIn;

        mem_rdAddrOut = '0;
        if (mem_rdReqOut) begin
            mem_rdAddrOut = {curTag, {OFFSET_WIDTH{1'b0}}} |
                            (ADDR_WIDTH'(issueCnt[BEAT_WIDTH-1:0]) << BYTE_BITS);
        end

        rsp_lineValidOut = (state == RSP_RESP);
        rsp_tagOut       = rsp_lineValidOut ? curTag  : '0;
        rsp_lineOut      = rsp_lineValidOut ? bufLine : '0;
        busyOut          = (state != RSP_IDLE);

        stateNext = state;
        case (state)
            RSP_IDLE: begin
                if (req_tagValidIn) begin
                    stateNext = bufHit ? RSP_RESP : RSP_FETCH;
                end
            end
            RSP_FETCH: begin
                // Completing the last beat wins over a late abort.
                if (lastBeat) begin
                    stateNext = RSP_RESP;
                end
`ifdef IFU_RSP_ABORT_EN
                else if (aborting && (rcvNext == issueCnt)) begin
                    stateNext = RSP_IDLE;
                end
`endif
            end
            RSP_RESP: stateNext = RSP_IDLE;
            default:  stateNext = RSP_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= RSP_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge Clock or negedge Rst_n) begin
        if (!Rst_n) begin
            curTag   <= '0;
            bufTag   <= '0;
            lineReg  <= '0;
            bufLine  <= '0;
            bufValid <= 1'b0;
            issueCnt <= '0;
            rcvCnt   <= '0;
`ifdef IFU_RSP_ABORT_EN
            abortReg <= 1'b0;
`endif
        end else begin
            case (state)
                RSP_IDLE: begin
                    if (req_tagValidIn) begin
                        curTag <= req_tagIn;
                        if (!bufHit) begin
                            issueCnt <= '0;
                            rcvCnt   <= '0;
`ifdef IFU_RSP_ABORT_EN
                            abortReg <= 1'b0;
`endif
                        end
                    end
                end
                RSP_FETCH: begin
                    if (rdAccept) begin
                        issueCnt <= issueCnt + CNT_WIDTH'(1);
                    end
                    if (rcvBeat) begin
                        lineReg <= lineNext;
                        rcvCnt  <= rcvCnt + CNT_WIDTH'(1);
                    end
                    if (lastBeat) begin
                        bufTag   <= curTag;
                        bufLine  <= lineNext;
                        bufValid <= 1'b1;
                    end
`ifdef IFU_RSP_ABORT_EN
                    if (aborting) begin
                        abortReg <= 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_mem_responder.sv
// Directed bench for ifu_mem_responder with a behavioural in-order memory (per-beat latency, stalls).
// Abort expectations follow IFU_RSP_ABORT_EN.
module tb_ifu_mem_responder;

    logic          Clock = 1'b0;
    logic          Rst_n = 1'b0;
    logic [27:0]   req_tagIn = '0;
    logic          req_tagValidIn = 1'b0;
    logic [27:0]   rsp_tagOut;
    logic [127:0]  rsp_lineOut;
    logic          rsp_lineValidOut;
    logic          mem_rdReqOut;
    logic [31:0]   mem_rdAddrOut;
    logic          mem_rdReadyIn = 1'b1;
    logic [31:0]   mem_rdDataIn = '0;
    logic          mem_rdDataValidIn = 1'b0;
    logic          busyOut;

    ifu_mem_responder dut (
        .Clock             (Clock),
        .Rst_n             (Rst_n),
        .req_tagIn         (req_tagIn),
        .req_tagValidIn    (req_tagValidIn),
        .rsp_tagOut        (rsp_tagOut),
        .rsp_lineOut       (rsp_lineOut),
        .rsp_lineValidOut  (rsp_lineValidOut),
        .mem_rdReqOut      (mem_rdReqOut),
        .mem_rdAddrOut     (mem_rdAddrOut),
        .mem_rdReadyIn     (mem_rdReadyIn),
        .mem_rdDataIn      (mem_rdDataIn),
        .mem_rdDataValidIn (mem_rdDataValidIn),
        .busyOut           (busyOut)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc++;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] L10 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] L20 = 128'h44444454_33333323_22222232_11111101;
    localparam logic [127:0] L30 = 128'h44444464_33333313_22222202_11111131;
    localparam logic [127:0] L40 = 128'h44444474_33333303_22222212_11111121;

    typedef struct {
        logic [27:0]      tag;
        logic [3:0][3:0]  lat;
        int               stallBeat;
        int               stallCyc;
        int               expDelta;
        int               expReads;
        logic [127:0]     expLine;
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } beat_t;

    beat_t           pend[$];
    logic [31:0]     addrLog[$];
    logic [31:0]     stallLog[$];
    logic [3:0][3:0] latCfg = 16'h1111;
    int              stallBeat = -1;
    int              stallLeft = 0;
    int              lastDue = 0;
    int              dueC;
    int              dataCnt = 0;
    int              rspCount = 0;
    int              rspCyc = 0;
    logic [27:0]     rspTag;
    logic [127:0]    rspLine;

    // Word value: (beat+1)*0x11111111, perturbed by (tag - 0x10) so that tag 0x10 gives the plain pattern.
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        logic [31:0] k;
        logic [31:0] tag;
        k   = 32'(addr[3:2]) + 32'd1;
        tag = addr >> 4;
        return (k * 32'h11111111) ^ (tag - 32'h10);
    endfunction

    always @(negedge Clock) begin
        if (!Rst_n) begin
            pend.delete();
            mem_rdDataValidIn = 1'b0;
            mem_rdDataIn      = '0;
            mem_rdReadyIn     = 1'b1;
            lastDue           = 0;
        end else begin
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                mem_rdDataValidIn = 1'b1;
                mem_rdDataIn      = pend[0].data;
                void'(pend.pop_front());
                dataCnt++;
            end else begin
                mem_rdDataValidIn = 1'b0;
                mem_rdDataIn      = '0;
            end
            mem_rdReadyIn = 1'b1;
            if (mem_rdReqOut) begin
                if (stallLeft > 0 && int'(mem_rdAddrOut[3:2]) == stallBeat) begin
                    mem_rdReadyIn = 1'b0;
                    stallLeft--;
                    stallLog.push_back(mem_rdAddrOut);
                end else begin
                    dueC = cyc + int'(latCfg[mem_rdAddrOut[3:2]]);
                    if (dueC <= lastDue) dueC = lastDue + 1;
                    lastDue = dueC;
                    pend.push_back('{dueC, memWord(mem_rdAddrOut)});
                    addrLog.push_back(mem_rdAddrOut);
                end
            end
            if (rsp_lineValidOut) begin
                rspCount++;
                rspCyc  = cyc;
                rspTag  = rsp_tagOut;
                rspLine = rsp_lineOut;
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic waitRsp(input int budget, input string name, output bit ok);
        int start;
        start = rspCount;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge Clock); #1;
            if (rspCount != start) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got no response, required one within %0d cycles", name, budget);
        end
    endtask

    task automatic pulseReset();
        @(posedge Clock); #1;
        req_tagValidIn = 1'b0;
        Rst_n = 1'b0;
        repeat (2) @(posedge Clock);
        #1 Rst_n = 1'b1;
    endtask

    task automatic runVec(input int idx, input vec_t v);
        int base;
        int t;
        bit ok;
        addrLog.delete();
        stallLog.delete();
        latCfg    = v.lat;
        stallBeat = v.stallBeat;
        stallLeft = v.stallCyc;
        base      = rspCount;
        @(posedge Clock); #1;
        req_tagIn      = v.tag;
        req_tagValidIn = 1'b1;
        t = cyc;
        waitRsp(40, $sformatf("v%0d rsp", idx), ok);
        req_tagValidIn = 1'b0;
        if (ok) begin
            check($sformatf("v%0d delta", idx), 128'(rspCyc - t), 128'(v.expDelta));
            check($sformatf("v%0d tag", idx), 128'(rspTag), 128'(v.tag));
            check($sformatf("v%0d line", idx), rspLine, v.expLine);
        end
        repeat (3) @(posedge Clock);
        #1;
        check($sformatf("v%0d pulses", idx), 128'(rspCount - base), 128'd1);
        check($sformatf("v%0d reads", idx), 128'(addrLog.size()), 128'(v.expReads));
        for (int i = 0; i < addrLog.size(); i++)
            check($sformatf("v%0d addr%0d", idx, i), 128'(addrLog[i]), 128'({v.tag, 2'(i), 2'b00}));
        if (v.stallCyc > 0) begin
            check($sformatf("v%0d stallcyc", idx), 128'(stallLog.size()), 128'(v.stallCyc));
            for (int i = 0; i < stallLog.size(); i++)
                check($sformatf("v%0d stalladdr%0d", idx, i), 128'(stallLog[i]),
                      128'({v.tag, 2'(v.stallBeat), 2'b00}));
        end
    endtask

    initial begin : main
        vec_t vecs[7];
        int base;
        int t;
        int c1;
        bit ok;

        vecs[0] = '{28'h10, 16'h1111, -1, 0,  6, 4, L10};
        vecs[1] = '{28'h10, 16'h1111, -1, 0,  1, 0, L10};
        vecs[2] = '{28'h30, 16'h1111,  2, 3,  9, 4, L30};
        vecs[3] = '{28'h40, 16'h7241, -1, 0, 12, 4, L40};
        vecs[4] = '{28'h40, 16'h1111, -1, 0,  1, 0, L40};
        vecs[5] = '{28'h10, 16'h2222, -1, 0,  7, 4, L10};
        vecs[6] = '{28'h10, 16'h1111, -1, 0,  6, 4, L10};

        repeat (2) @(posedge Clock);
        #1;
        check("rst valid", 128'(rsp_lineValidOut), 128'd0);
        check("rst tag",   128'(rsp_tagOut), 128'd0);
        check("rst line",  rsp_lineOut, 128'd0);
        check("rst rdreq", 128'(mem_rdReqOut), 128'd0);
        check("rst addr",  128'(mem_rdAddrOut), 128'd0);
        check("rst busy",  128'(busyOut), 128'd0);
        Rst_n = 1'b1;

        for (int i = 0; i < 6; i++) runVec(i, vecs[i]);

        // Request held through the response: a second (buffer-hit) pulse after one IDLE cycle.
        base = rspCount;
        @(posedge Clock); #1;
        req_tagIn = 28'h10;
        req_tagValidIn = 1'b1;
        t = cyc;
        waitRsp(10, "b2b rsp1", ok);
        c1 = rspCyc;
        if (ok) check("b2b delta1", 128'(c1 - t), 128'd1);
        waitRsp(10, "b2b rsp2", ok);
        req_tagValidIn = 1'b0;
        if (ok) check("b2b gap", 128'(rspCyc - c1), 128'd2);
        repeat (3) @(posedge Clock);
        #1;
        check("b2b pulses", 128'(rspCount - base), 128'd2);

        // Reset after two beats have been received.
        latCfg = 16'h1111;
        stallLeft = 0;
        base = dataCnt;
        c1 = rspCount;
        @(posedge Clock); #1;
        req_tagIn = 28'h60;
        req_tagValidIn = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge Clock); #1;
            if (dataCnt - base >= 2) ok = 1'b1;
        end
        check("midrst two beats", 128'(ok), 128'd1);
        check("midrst busy before", 128'(busyOut), 128'd1);
        #2;
        req_tagValidIn = 1'b0;
        Rst_n = 1'b0;
        #1;
        check("midrst busy",  128'(busyOut), 128'd0);
        check("midrst rdreq", 128'(mem_rdReqOut), 128'd0);
        check("midrst addr",  128'(mem_rdAddrOut), 128'd0);
        check("midrst valid", 128'(rsp_lineValidOut), 128'd0);
        check("midrst line",  rsp_lineOut, 128'd0);
        repeat (2) @(posedge Clock);
        #1 Rst_n = 1'b1;
        check("midrst no rsp", 128'(rspCount - c1), 128'd0);
        runVec(6, vecs[6]);

        // Tag changes to 0x20 after the first read of a 0x10 fetch is accepted.
        pulseReset();
        addrLog.delete();
        latCfg = 16'h3333;
        stallLeft = 0;
        base = rspCount;
        @(posedge Clock); #1;
        req_tagIn = 28'h10;
        req_tagValidIn = 1'b1;
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        req_tagIn = 28'h20;
        waitRsp(60, "abort rsp1", ok);
`ifdef IFU_RSP_ABORT_EN
        req_tagValidIn = 1'b0;
        if (ok) begin
            check("abort tag",  128'(rspTag), 128'h20);
            check("abort line", rspLine, L20);
        end
        repeat (3) @(posedge Clock);
        #1;
        check("abort pulses", 128'(rspCount - base), 128'd1);
        check("abort reads",  128'(addrLog.size()), 128'd5);
        check("abort first",  128'(addrLog[0]), 128'h100);
        check("abort refetch", 128'(addrLog[1]), 128'h200);
`else
        if (ok) begin
            check("noabort tag1",  128'(rspTag), 128'h10);
            check("noabort line1", rspLine, L10);
        end
        waitRsp(60, "noabort rsp2", ok);
        req_tagValidIn = 1'b0;
        if (ok) begin
            check("noabort tag2",  128'(rspTag), 128'h20);
            check("noabort line2", rspLine, L20);
        end
        repeat (3) @(posedge Clock);
        #1;
        check("noabort pulses", 128'(rspCount - base), 128'd2);
        check("noabort reads",  128'(addrLog.size()), 128'd8);
        check("noabort last10", 128'(addrLog[3]), 128'h10C);
        check("noabort first20", 128'(addrLog[4]), 128'h200);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
